// File: rtl/peripheral_tl_burst_sequencer.sv
// Burst address sequencer: accepts one burst command and emits per-beat
// addresses (SINGLE/INCR/INCRx/WRAPx) with valid/ready handshaking.
module peripheral_tl_burst_sequencer #(
    parameter int PLEN = 32,
    parameter int XLEN = 32,
    parameter int LENW = 8
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            cmd_valid_i,
    output logic            cmd_ready_o,
    input  logic [PLEN-1:0] cmd_addr_i,
    input  logic [2:0]      cmd_size_i,
    input  logic [2:0]      cmd_burst_i,
    input  logic [2:0]      cmd_prot_i,
    input  logic            cmd_write_i,
    input  logic [LENW-1:0] cmd_len_i,
    output logic            beat_valid_o,
    input  logic            beat_ready_i,
    output logic [PLEN-1:0] beat_addr_o,
    output logic [2:0]      beat_size_o,
    output logic [2:0]      beat_prot_o,
    output logic            beat_write_o,
    output logic            beat_first_o,
    output logic            beat_last_o,
    output logic [LENW-1:0] beat_idx_o,
    output logic            busy_o,
    output logic            err_o
);

    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] ACTIVE = 1'b1;

    localparam logic [2:0] MAX_SIZE = 3'($clog2(XLEN / 8));

    localparam logic [2:0] B_SINGLE = 3'b000;
    localparam logic [2:0] B_INCR   = 3'b001;
    localparam logic [2:0] B_WRAP4  = 3'b010;
    localparam logic [2:0] B_INCR4  = 3'b011;
    localparam logic [2:0] B_WRAP8  = 3'b100;
    localparam logic [2:0] B_INCR8  = 3'b101;
    localparam logic [2:0] B_WRAP16 = 3'b110;
    localparam logic [2:0] B_INCR16 = 3'b111;

    logic [0:0]      state_q, state_d;
    logic [PLEN-1:0] addr_q, addr_d;
    logic [PLEN-1:0] mask_q, mask_d;
    logic [2:0]      size_q, size_d;
    logic [2:0]      prot_q, prot_d;
    logic            write_q, write_d;
    logic            wrap_q, wrap_d;
    logic [LENW-1:0] idx_q, idx_d;
    logic [LENW-1:0] last_q, last_d;
    logic            err_q, err_d;

    logic            accept;
    logic            cmd_illegal;
    logic [LENW-1:0] cmd_last;
    logic [PLEN-1:0] step;
    logic [PLEN-1:0] addr_inc;
    logic [PLEN-1:0] addr_next;

    always_comb begin
        case (cmd_burst_i)
            B_SINGLE:          cmd_last = '0;
            B_INCR:            cmd_last = cmd_len_i;
            B_WRAP4, B_INCR4:  cmd_last = LENW'(3);
            B_WRAP8, B_INCR8:  cmd_last = LENW'(7);
            B_WRAP16, B_INCR16: cmd_last = LENW'(15);
            default:           cmd_last = '0;
        endcase
    end

    assign accept      = cmd_valid_i && (state_q == IDLE);
    assign cmd_illegal = (cmd_size_i > MAX_SIZE) ||
                         ((cmd_addr_i & ((PLEN'(1) << cmd_size_i) - PLEN'(1))) != '0);

    // Wrap keeps the bits above the burst-size mask and increments inside it.
    assign step      = PLEN'(1) << size_q;
    assign addr_inc  = addr_q + step;
    assign addr_next = wrap_q ? ((addr_q & ~mask_q) | (addr_inc & mask_q)) : addr_inc;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        mask_d  = mask_q;
        size_d  = size_q;
        prot_d  = prot_q;
        write_d = write_q;
        wrap_d  = wrap_q;
        idx_d   = idx_q;
        last_d  = last_q;
        err_d   = 1'b0;

        if (accept) begin
            if (cmd_illegal) begin
                err_d = 1'b1;
            end else begin
                state_d = ACTIVE;
                addr_d  = cmd_addr_i;
                size_d  = cmd_size_i;
                prot_d  = cmd_prot_i;
                write_d = cmd_write_i;
                wrap_d  = (cmd_burst_i == B_WRAP4) || (cmd_burst_i == B_WRAP8) ||
                          (cmd_burst_i == B_WRAP16);
                idx_d   = '0;
                last_d  = cmd_last;
                mask_d  = ((PLEN'(cmd_last) + PLEN'(1)) << cmd_size_i) - PLEN'(1);
            end
        end else if ((state_q == ACTIVE) && beat_ready_i) begin
            if (idx_q == last_q) begin
                state_d = IDLE;
            end else begin
                idx_d  = idx_q + LENW'(1);
                addr_d = addr_next;
            end
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= IDLE;
            addr_q  <= '0;
            mask_q  <= '0;
            size_q  <= '0;
            prot_q  <= '0;
            write_q <= 1'b0;
            wrap_q  <= 1'b0;
            idx_q   <= '0;
            last_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            mask_q  <= mask_d;
            size_q  <= size_d;
            prot_q  <= prot_d;
            write_q <= write_d;
            wrap_q  <= wrap_d;
            idx_q   <= idx_d;
            last_q  <= last_d;
            err_q   <= err_d;
        end
    end

    assign cmd_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q == ACTIVE);
    assign beat_valid_o = (state_q == ACTIVE);
    assign beat_addr_o  = addr_q;
    assign beat_size_o  = size_q;
    assign beat_prot_o  = prot_q;
    assign beat_write_o = write_q;
    assign beat_idx_o   = idx_q;
    assign beat_first_o = (state_q == ACTIVE) && (idx_q == '0);
    assign beat_last_o  = (state_q == ACTIVE) && (idx_q == last_q);
    assign err_o        = err_q;

endmodule

// File: tb/tb_peripheral_tl_burst_sequencer.sv
// Self-checking bench for peripheral_tl_burst_sequencer: vector table,
// hand-written corner sequences and random bursts against an arithmetic model.
module tb_peripheral_tl_burst_sequencer;

    localparam int PLEN = 32;
    localparam int XLEN = 32;
    localparam int LENW = 8;

    logic            HCLK = 1'b0;
    logic            HRESETn;
    logic            cmd_valid_i;
    logic            cmd_ready_o;
    logic [PLEN-1:0] cmd_addr_i;
    logic [2:0]      cmd_size_i;
    logic [2:0]      cmd_burst_i;
    logic [2:0]      cmd_prot_i;
    logic            cmd_write_i;
    logic [LENW-1:0] cmd_len_i;
    logic            beat_valid_o;
    logic            beat_ready_i;
    logic [PLEN-1:0] beat_addr_o;
    logic [2:0]      beat_size_o;
    logic [2:0]      beat_prot_o;
    logic            beat_write_o;
    logic            beat_first_o;
    logic            beat_last_o;
    logic [LENW-1:0] beat_idx_o;
    logic            busy_o;
    logic            err_o;

    peripheral_tl_burst_sequencer #(.PLEN(PLEN), .XLEN(XLEN), .LENW(LENW)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_addr_i(cmd_addr_i), .cmd_size_i(cmd_size_i), .cmd_burst_i(cmd_burst_i),
        .cmd_prot_i(cmd_prot_i), .cmd_write_i(cmd_write_i), .cmd_len_i(cmd_len_i),
        .beat_valid_o(beat_valid_o), .beat_ready_i(beat_ready_i),
        .beat_addr_o(beat_addr_o), .beat_size_o(beat_size_o), .beat_prot_o(beat_prot_o),
        .beat_write_o(beat_write_o), .beat_first_o(beat_first_o), .beat_last_o(beat_last_o),
        .beat_idx_o(beat_idx_o), .busy_o(busy_o), .err_o(err_o)
    );

    always #5 HCLK = ~HCLK;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    function automatic int model_n(input logic [2:0] bu, input logic [7:0] ln);
        case (bu)
            3'd0:       return 1;
            3'd1:       return int'(ln) + 1;
            3'd2, 3'd3: return 4;
            3'd4, 3'd5: return 8;
            default:    return 16;
        endcase
    endfunction

    function automatic logic model_illegal(input logic [31:0] a, input logic [2:0] sz);
        longint s;
        s = longint'(1) << sz;
        return (sz > 3'd2) || ((longint'(a) % s) != 0);
    endfunction

    function automatic logic [31:0] model_addr(input logic [31:0] a, input logic [2:0] sz,
                                               input logic [2:0] bu, input int n, input int k);
        longint s, b, base;
        s = longint'(1) << sz;
        if (bu == 3'd2 || bu == 3'd4 || bu == 3'd6) begin
            b    = longint'(n) * s;
            base = (longint'(a) / b) * b;
            return 32'(base + ((longint'(a) - base + longint'(k) * s) % b));
        end
        return 32'(longint'(a) + longint'(k) * s);
    endfunction

    task automatic check_reset_vals(input string name);
        logic [52:0] act;
        act = {cmd_ready_o, beat_valid_o, busy_o, err_o, beat_addr_o, beat_size_o,
               beat_prot_o, beat_write_o, beat_first_o, beat_last_o, beat_idx_o};
        check(name, 64'(act), 64'({1'b1, 52'b0}));
    endtask

    // Issues one command from a negedge and follows it to completion.
    // mode: 0 = always ready, 1 = ready pattern 1,0,0 repeating, 2 = random ready.
    task automatic do_burst(input logic [31:0] a, input logic [2:0] sz, input logic [2:0] bu,
                            input logic [7:0] ln, input int mode,
                            output int obs_n, output logic [31:0] obs_a0,
                            output logic [31:0] obs_al, output logic obs_err);
        int n, hs, cyc;
        logic ill, r, v, stalled, wr;
        logic [2:0] pr;
        logic [48:0] exp_b, act_b, prev_b;
        ill = model_illegal(a, sz);
        n   = model_n(bu, ln);
        pr  = 3'($urandom);
        wr  = 1'($urandom);
        obs_n = 0; obs_a0 = '0; obs_al = '0;
        prev_b = '0;
        check("cmd_ready_idle", 64'(cmd_ready_o), 64'd1);
        cmd_valid_i = 1'b1; cmd_addr_i = a; cmd_size_i = sz; cmd_burst_i = bu;
        cmd_len_i = ln; cmd_prot_i = pr; cmd_write_i = wr; beat_ready_i = 1'b0;
        @(negedge HCLK);
        cmd_valid_i = 1'b0;
        obs_err = err_o;
        if (ill) begin
            check("err_pulse", 64'(err_o), 64'd1);
            check("no_beat_on_err", 64'(beat_valid_o), 64'd0);
            @(negedge HCLK);
            check("err_one_cycle", 64'(err_o), 64'd0);
            check("no_beat_after_err", 64'(beat_valid_o), 64'd0);
            return;
        end
        check("no_err_legal", 64'(err_o), 64'd0);
        check("busy_set", 64'(busy_o), 64'd1);
        hs = 0; cyc = 0; stalled = 1'b0;
        while (hs < n && cyc < n * 4 + 8) begin
            v = beat_valid_o;
            check("beat_valid", 64'(v), 64'd1);
            exp_b = {model_addr(a, sz, bu, n, hs), 8'(hs), hs == 0, hs == n - 1, sz, pr, wr};
            act_b = {beat_addr_o, beat_idx_o, beat_first_o, beat_last_o,
                     beat_size_o, beat_prot_o, beat_write_o};
            check("beat_fields", 64'(act_b), 64'(exp_b));
            if (stalled) check("stall_hold", 64'(act_b), 64'(prev_b));
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            beat_ready_i = r;
            if (hs == 0) obs_a0 = beat_addr_o;
            obs_al  = beat_addr_o;
            prev_b  = act_b;
            stalled = !r;
            @(negedge HCLK);
            if (r && v) hs++;
            cyc++;
        end
        beat_ready_i = 1'b0;
        if (hs < n) check("burst_timeout", 64'(hs), 64'(n));
        obs_n = hs;
        if (mode == 0) check("throughput_cycles", 64'(cyc), 64'(n));
        check("valid_drops", 64'(beat_valid_o), 64'd0);
        check("ready_returns", 64'(cmd_ready_o), 64'd1);
        check("busy_clears", 64'(busy_o), 64'd0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [2:0]  size;
        logic [2:0]  burst;
        logic [7:0]  len;
        int          mode;
        logic        err;
        int          n;
        logic [31:0] a0;
        logic [31:0] alast;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int o_n;
        logic [31:0] o_a0, o_al;
        logic o_err;

        vecs[0]  = '{32'h0000_0100, 3'd2, 3'd0, 8'd0,   0, 1'b0, 1,   32'h0000_0100, 32'h0000_0100};
        vecs[1]  = '{32'h0000_0038, 3'd2, 3'd2, 8'd0,   0, 1'b0, 4,   32'h0000_0038, 32'h0000_0034};
        vecs[2]  = '{32'h0000_1000, 3'd1, 3'd5, 8'd0,   1, 1'b0, 8,   32'h0000_1000, 32'h0000_100E};
        vecs[3]  = '{32'hFFFF_FFFF, 3'd0, 3'd1, 8'd2,   0, 1'b0, 3,   32'hFFFF_FFFF, 32'h0000_0001};
        vecs[4]  = '{32'h0000_0102, 3'd2, 3'd0, 8'd0,   0, 1'b1, 0,   32'h0,         32'h0};
        vecs[5]  = '{32'h0000_0100, 3'd3, 3'd3, 8'd0,   0, 1'b1, 0,   32'h0,         32'h0};
        vecs[6]  = '{32'h0000_0200, 3'd2, 3'd7, 8'd0,   0, 1'b0, 16,  32'h0000_0200, 32'h0000_023C};
        vecs[7]  = '{32'h0000_000E, 3'd1, 3'd4, 8'd0,   1, 1'b0, 8,   32'h0000_000E, 32'h0000_000C};
        vecs[8]  = '{32'h0000_0005, 3'd0, 3'd6, 8'd0,   0, 1'b0, 16,  32'h0000_0005, 32'h0000_0004};
        vecs[9]  = '{32'h0000_0007, 3'd0, 3'd1, 8'd0,   0, 1'b0, 1,   32'h0000_0007, 32'h0000_0007};
        vecs[10] = '{32'h0000_0000, 3'd2, 3'd1, 8'd255, 0, 1'b0, 256, 32'h0000_0000, 32'h0000_03FC};

        HRESETn = 1'b0; cmd_valid_i = 1'b0; cmd_addr_i = '0; cmd_size_i = '0;
        cmd_burst_i = '0; cmd_prot_i = '0; cmd_write_i = 1'b0; cmd_len_i = '0;
        beat_ready_i = 1'b0;
        @(negedge HCLK); @(negedge HCLK);
        check_reset_vals("reset_values");
        HRESETn = 1'b1;
        @(negedge HCLK);
        check_reset_vals("idle_after_release");

        foreach (vecs[i]) begin
            do_burst(vecs[i].addr, vecs[i].size, vecs[i].burst, vecs[i].len, vecs[i].mode,
                     o_n, o_a0, o_al, o_err);
            check($sformatf("tbl%0d_err", i), 64'(o_err), 64'(vecs[i].err));
            if (!vecs[i].err) begin
                check($sformatf("tbl%0d_beats", i), 64'(o_n), 64'(vecs[i].n));
                check($sformatf("tbl%0d_first_addr", i), 64'(o_a0), 64'(vecs[i].a0));
                check($sformatf("tbl%0d_last_addr", i), 64'(o_al), 64'(vecs[i].alast));
            end
        end

        // Legal command issued in the cycle err_o is high.
        cmd_valid_i = 1'b1; cmd_addr_i = 32'h102; cmd_size_i = 3'd2; cmd_burst_i = 3'd0;
        cmd_len_i = '0;
        @(negedge HCLK);
        check("errcyc_err", 64'(err_o), 64'd1);
        check("errcyc_ready", 64'(cmd_ready_o), 64'd1);
        cmd_addr_i = 32'h44; cmd_prot_i = 3'd5; cmd_write_i = 1'b1;
        @(negedge HCLK);
        cmd_valid_i = 1'b0;
        check("errcyc_err_clear", 64'(err_o), 64'd0);
        check("errcyc_beat", 64'({beat_valid_o, beat_addr_o, beat_first_o, beat_last_o}),
              64'({1'b1, 32'h44, 1'b1, 1'b1}));
        beat_ready_i = 1'b1;
        @(negedge HCLK);
        beat_ready_i = 1'b0;
        check("errcyc_done", 64'(beat_valid_o), 64'd0);

        // Reset in the middle of a WRAP16 after the idx 5 handshake.
        cmd_valid_i = 1'b1; cmd_addr_i = 32'h24; cmd_size_i = 3'd2; cmd_burst_i = 3'd6;
        @(negedge HCLK);
        cmd_valid_i = 1'b0;
        beat_ready_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("rst_seq_addr", 64'({beat_valid_o, beat_idx_o, beat_addr_o}),
                  64'({1'b1, 8'(i), model_addr(32'h24, 3'd2, 3'd6, 16, i)}));
            @(negedge HCLK);
        end
        beat_ready_i = 1'b0;
        check("rst_seq_idx6", 64'(beat_idx_o), 64'd6);
        HRESETn = 1'b0;
        #1;
        check_reset_vals("reset_mid_burst");
        @(negedge HCLK);
        check_reset_vals("reset_mid_burst_held");
        HRESETn = 1'b1;
        @(negedge HCLK);
        check("no_err_after_reset", 64'(err_o), 64'd0);
        do_burst(32'h0, 3'd2, 3'd0, 8'd0, 0, o_n, o_a0, o_al, o_err);
        check("post_reset_single", 64'({o_n[7:0], o_a0}), 64'({8'd1, 32'h0}));

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  sz;
            logic [31:0] a;
            sz = 3'($urandom_range(0, 3));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) a = a & ~((32'd1 << sz) - 32'd1);
            do_burst(a, sz, 3'($urandom), 8'($urandom_range(0, 20)), 2, o_n, o_a0, o_al, o_err);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/peripheral_tl_burst_sequencer.md
# peripheral_tl_burst_sequencer

Burst sequencer for the TileLink/AHB-Lite peripheral bus. It accepts one burst command (start address, size, burst type, protection, direction) and emits the per-beat address stream with valid/ready handshaking. It covers the SINGLE, INCR, INCR4/8/16 and WRAP4/8/16 encodings of the bus constants package. It sits between a master's request logic and the bus address phase, so masters need no beat arithmetic of their own.

## Interface
- PLEN, 32: address width in bits.
- XLEN, 32: data width in bits; maximum legal size is log2(XLEN/8), which is 2 (WORD) at the default.
- LENW, 8: width of the INCR length field.

- HCLK  input  1  clock; all state on the rising edge.
- HRESETn  input  1  reset, asynchronous assert, active-low.
- cmd_valid_i  input  1  burst command present.
- cmd_ready_o  output  1  sequencer idle and able to accept a command.
- cmd_addr_i  input  PLEN  start address.
- cmd_size_i  input  3  BYTE=000, HWORD=001, WORD=010, DWORD=011, QWORD=100.
- cmd_burst_i  input  3  SINGLE=000, INCR=001, WRAP4=010, INCR4=011, WRAP8=100, INCR8=101, WRAP16=110, INCR16=111.
- cmd_prot_i  input  3  protection code, passed through unchanged.
- cmd_write_i  input  1  1 = write burst.
- cmd_len_i  input  LENW  beats minus 1; used for INCR only, ignored for all other burst types.
- beat_valid_o  output  1  beat address valid.
- beat_ready_i  input  1  downstream accepts the beat.
- beat_addr_o  output  PLEN  beat address.
- beat_size_o / beat_prot_o / beat_write_o  output  3/3/1  command fields latched at accept.
- beat_first_o, beat_last_o  output  1  first and last beat of the burst.
- beat_idx_o  output  LENW  beat index, starting at 0.
- busy_o  output  1  burst in progress.
- err_o  output  1  one-cycle pulse when an illegal command is rejected.

## Operation
- FSM has two states, IDLE and ACTIVE. cmd_ready_o = (state==IDLE). busy_o = (state==ACTIVE).
- **Accept:** a command is accepted when cmd_valid_i && cmd_ready_o.
- **Legal command:** the command is latched and the state moves to ACTIVE. The beat count N is:
  - SINGLE: 1
  - INCR: cmd_len_i+1
  - WRAP4/INCR4: 4
  - WRAP8/INCR8: 8
  - WRAP16/INCR16: 16
- **Illegal command:** the command is illegal if cmd_size_i > log2(XLEN/8), or if cmd_addr_i is misaligned (addr & ((1<<size)-1) != 0).
  - The command is still consumed.
  - The state stays IDLE.
  - err_o pulses high the next cycle.
  - No beat is produced.
- **Beat handshake:** a beat completes on beat_valid_o && beat_ready_i. While beat_valid_o=1 and beat_ready_i=0, every beat_* output holds stable.
- **Step:** S = 1<<size.
- **INCR-class next address:** addr+S, modulo 2^PLEN. There is no 1 KB boundary check.
- **WRAP-class next address:** with B = N*S, next = (addr & ~(B-1)) | ((addr+S) & (B-1)).
- beat_first_o = (idx==0). beat_last_o = (idx==N-1).
- **End of burst:** on the last-beat handshake the state returns to IDLE and beat_valid_o drops the next cycle.

## Timing
- **Reset values:** state IDLE. cmd_ready_o=1. beat_valid_o=0, busy_o=0, err_o=0. beat_addr_o=0, beat_idx_o=0, and all other beat_* outputs are 0.
- **Reset mid-burst:** the burst is abandoned immediately, with no last beat and no error.
- **Latency:** a command accepted in cycle T gives beat_valid_o=1 with beat 0 in cycle T+1.
- **Throughput:** one beat per cycle while beat_ready_i=1. An N-beat burst occupies N cycles in ACTIVE.
- **Command gap:** after the last-beat handshake in cycle T, cmd_ready_o=1 in T+1. There is no same-cycle command accept during ACTIVE.
- **Error timing:** an illegal command accepted in T gives err_o=1 in T+1 only. cmd_ready_o stays 1 throughout, so a new command can be accepted in T+1.
- **INCR length:** cmd_len_i=0 gives a 1-beat INCR; the maximum is 2^LENW beats.

## Test plan
- **SINGLE:** WORD, addr 0x100 -> one beat at 0x100 with first=last=1 and idx=0. cmd_ready_o returns 1 the cycle after the handshake.
- **WRAP4:** WORD, addr 0x38 -> beats 0x38, 0x3C, 0x30, 0x34. last=1 on idx 3 only.
- **INCR8 with stalls:** HWORD, addr 0x1000, beat_ready_i toggling 1,0,0,1,... -> addresses 0x1000..0x100E in steps of 2. Outputs are held unchanged during every stall cycle. Exactly 8 handshakes occur.
- **INCR address wrap:** INCR, cmd_len_i=2, BYTE, addr 0xFFFFFFFF -> beats 0xFFFFFFFF, 0x00000000, 0x00000001.
- **Error cases:**
  - WORD at addr 0x102 -> err_o=1 for exactly one cycle and beat_valid_o stays 0.
  - DWORD with XLEN=32 -> same response.
  - A legal command issued in the err_o cycle is accepted.
- **Reset mid-burst:** WRAP16, WORD, addr 0x24, HRESETn asserted after the idx 5 handshake -> all outputs take their reset values immediately. After release, a SINGLE at 0x0 produces a beat with idx=0 and first=1.
